conway_stepper: RTL
===================

CONWAY_STEPPER -- requirements
Module: conway_stepper

Interface
REQ-001 Parameter ROWS, default 8, grid row count (2..64).
REQ-002 Parameter COLS, default 8, grid column count (2..64); N = ROWS*COLS.
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 load_valid  in  1  seed bit present on load_data.
REQ-006 load_data  in  1  serial seed bit.
REQ-007 start  in  1  one-cycle request to run a job.
REQ-008 num_gens  in  16  generations to advance per job.
REQ-009 cells_q  in  N  current cell states from the grid; bit r*COLS+c is cell (r,c).
REQ-010 seed  out  N  initial-state vector, drives every cell's state_0.
REQ-011 grid_rst  out  1  active-high synchronous load strobe to grid cells.
REQ-012 grid_ena  out  1  active-high generation-advance enable to grid cells.
REQ-013 out_valid  out  1  serial readout bit valid.
REQ-014 out_data  out  1  serial readout bit.
REQ-015 out_ready  in  1  downstream accepts out_data.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 done  out  1  one-cycle pulse when a job's readout completes.
REQ-018 gen_count  out  16  generations advanced in the current/last job.

Function
REQ-019 FSM states SHALL be IDLE, APPLY, RUN, DUMP; all outputs registered.
REQ-020 In IDLE, each cycle with load_valid=1 SHALL set seed <= {load_data, seed[N-1:1]}; after N bits the first bit sits at seed[0].
REQ-021 load_valid outside IDLE SHALL be ignored; seed holds.
REQ-022 start in IDLE SHALL go to APPLY and clear gen_count to 0; start outside IDLE is ignored.
REQ-023 If load_valid and start coincide in IDLE, the bit SHALL shift and the job SHALL start on the updated seed.
REQ-024 num_gens SHALL be sampled into an internal register on the accepted start; later changes are ignored.
REQ-025 APPLY SHALL last exactly one cycle with grid_rst=1, grid_ena=0, then go to RUN.
REQ-026 In RUN, grid_ena SHALL be 1 for exactly num_gens consecutive cycles, gen_count incrementing once per cycle grid_ena=1.
REQ-027 num_gens=0 SHALL skip RUN (APPLY -> DUMP) with no grid_ena pulse.
REQ-028 On leaving RUN, grid_ena SHALL be 0 and cells_q SHALL be captured into a snapshot register one cycle after the last grid_ena cycle, so the snapshot reflects the final generation.
REQ-029 In DUMP, out_data SHALL present snapshot bits index 0 to N-1; out_valid=1 throughout.
REQ-030 A bit transfers when out_valid & out_ready; out_data and out_valid SHALL be held stable while out_ready=0.
REQ-031 After bit N-1 transfers, the FSM SHALL go to IDLE, out_valid drops the next cycle, and done pulses for one cycle.
REQ-032 gen_count SHALL hold its final value in IDLE until the next accepted start.
REQ-033 grid_rst and grid_ena SHALL never be 1 in the same cycle.

Reset
REQ-034 rst=0 SHALL asynchronously force IDLE, seed=0, grid_rst=0, grid_ena=0, out_valid=0, out_data=0, done=0, busy=0, gen_count=0, bit index=0.
REQ-035 rst asserted mid-job (any state) SHALL abort the job with no done pulse; release returns to IDLE with the outputs listed in REQ-034.
REQ-036 Outputs SHALL first change on the first posedge after rst deasserts.

Verification
REQ-037 8x8, shift 64 bits encoding a blinker at (3,2)(3,3)(3,4), start, num_gens=1 -> one grid_rst cycle, one grid_ena cycle, readout bits 19,27,35 =1, all others 0, done pulse, gen_count=1.
REQ-038 Same seed, num_gens=0 -> no grid_ena pulse, readout equals seed, gen_count=0.
REQ-039 num_gens=5, out_ready toggled 1/0 every cycle -> 64 transfers, stable out_data during stalls, exactly 5 grid_ena cycles.
REQ-040 rst pulsed low during RUN after 2 of 10 generations -> immediate IDLE, grid_ena=0, no done, gen_count=0, seed=0.
REQ-041 start and load_valid in the same IDLE cycle, plus start while busy -> seed shifted once, second start ignored, single done pulse.

Source files
------------

// File: rtl/conway_stepper_if.sv
// ----------------------------------------------------------------------------
// conway_stepper_if
//   Host-side bundle of the Conway stepper: serial seed loading, job control,
//   job status and the serial readout stream.
//
//   load_valid / load_data : one seed bit per cycle, accepted while idle
//   start / num_gens       : one-cycle job request and its generation count
//   out_valid / out_data   : readout bit stream, out_ready is the back-pressure
//   busy / done / gen_count: job status
//
//   master : the host (drives load, start, num_gens, out_ready)
//   slave  : the stepper
// ----------------------------------------------------------------------------
interface conway_stepper_if;
    logic        load_valid;
    logic        load_data;
    logic        start;
    logic [15:0] num_gens;
    logic        out_valid;
    logic        out_data;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic [15:0] gen_count;

    modport master (
        output load_valid, load_data, start, num_gens, out_ready,
        input  out_valid, out_data, busy, done, gen_count
    );

    modport slave (
        input  load_valid, load_data, start, num_gens, out_ready,
        output out_valid, out_data, busy, done, gen_count
    );
endinterface

// File: rtl/conway_stepper.sv
// ----------------------------------------------------------------------------
// conway_stepper
//   Sequencer for an external ROWS x COLS Game-of-Life cell array. A seed is
//   shifted in serially, a job loads the seed into the array (grid_rst), lets
//   it advance num_gens generations (grid_ena), snapshots the final state and
//   streams it out one bit at a time with valid/ready handshaking.
//
// Ports
//   clk       : clock, all state changes on its rising edge
//   rst       : asynchronous active-low reset
//   bus       : host bundle (seed load, start/num_gens, readout, status)
//   cells_q   : current cell states, bit r*COLS+c is cell (r,c)
//   seed      : seed vector fed to every cell's initial-state input
//   grid_rst  : one-cycle strobe loading seed into the cells
//   grid_ena  : generation-advance enable for the cells
// ----------------------------------------------------------------------------
module conway_stepper #(
    parameter int ROWS = 8,
    parameter int COLS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    conway_stepper_if.slave      bus,
    input  logic [ROWS*COLS-1:0] cells_q,
    output logic [ROWS*COLS-1:0] seed,
    output logic                 grid_rst,
    output logic                 grid_ena
);
    localparam int N     = ROWS * COLS;
    localparam int IDX_W = $clog2(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {IDLE, APPLY, RUN, DUMP} state_t;

    state_t           state_reg;
    logic [N-1:0]     seed_reg;
    logic [N-1:0]     snap_reg;
    logic [15:0]      gens_reg;
    logic [15:0]      gen_count_reg;
    logic [IDX_W-1:0] bit_idx_reg;
    logic             grid_rst_reg;
    logic             grid_ena_reg;
    logic             out_valid_reg;
    logic             out_data_reg;
    logic             busy_reg;
    logic             done_reg;

    logic [IDX_W-1:0] bit_idx_next;
    logic [15:0]      gen_count_next;

    assign bit_idx_next   = bit_idx_reg + IDX_W'(1);
    assign gen_count_next = gen_count_reg + 16'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            seed_reg      <= '0;
            snap_reg      <= '0;
            gens_reg      <= '0;
            gen_count_reg <= '0;
            bit_idx_reg   <= '0;
            grid_rst_reg  <= 1'b0;
            grid_ena_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // A bit arriving with start still shifts in, so the job
                    // (which loads the grid one cycle later) sees it.
                    if (bus.load_valid) begin
                        seed_reg <= {bus.load_data, seed_reg[N-1:1]};
                    end
                    if (bus.start) begin
                        state_reg     <= APPLY;
                        gens_reg      <= bus.num_gens;
                        gen_count_reg <= '0;
                        grid_rst_reg  <= 1'b1;
                        busy_reg      <= 1'b1;
                    end
                end

                APPLY: begin
                    grid_rst_reg <= 1'b0;
                    if (gens_reg == 16'd0) begin
                        // No generations: the final state is the seed itself,
                        // so snapshot it directly instead of waiting for the
                        // grid to reflect the load.
                        state_reg     <= DUMP;
                        snap_reg      <= seed_reg;
                        out_valid_reg <= 1'b1;
                        out_data_reg  <= seed_reg[0];
                        bit_idx_reg   <= '0;
                    end else begin
                        state_reg    <= RUN;
                        grid_ena_reg <= 1'b1;
                    end
                end

                RUN: begin
                    if (grid_ena_reg) begin
                        gen_count_reg <= gen_count_next;
                        if (gen_count_next == gens_reg) begin
                            grid_ena_reg <= 1'b0;
                        end
                    end else begin
                        // First cycle after the last enable: cells_q now holds
                        // the final generation.
                        state_reg     <= DUMP;
                        snap_reg      <= cells_q;
                        out_valid_reg <= 1'b1;
                        out_data_reg  <= cells_q[0];
                        bit_idx_reg   <= '0;
                    end
                end

                DUMP: begin
                    if (bus.out_ready) begin
                        if (bit_idx_reg == LAST_IDX) begin
                            state_reg     <= IDLE;
                            out_valid_reg <= 1'b0;
                            out_data_reg  <= 1'b0;
                            bit_idx_reg   <= '0;
                            busy_reg      <= 1'b0;
                            done_reg      <= 1'b1;
                        end else begin
                            bit_idx_reg  <= bit_idx_next;
                            out_data_reg <= snap_reg[bit_idx_next];
                        end
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign seed          = seed_reg;
    assign grid_rst      = grid_rst_reg;
    assign grid_ena      = grid_ena_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.busy      = busy_reg;
    assign bus.done      = done_reg;
    assign bus.gen_count = gen_count_reg;

endmodule
